// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: PC register link, instruction-memory handshake and decode-side queue port.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
    parameter int AW = 32
);
    logic [AW-1:0] pc_in;
    logic          pc_enable;
    logic          redirect;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;

    modport master (
        input  pc_in, redirect, imem_ack, imem_rdata, inst_ready,
        output pc_enable, imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output pc_in, redirect, imem_ack, imem_rdata, inst_ready,
        input  pc_enable, imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word fetch at a time, results queued with their PC
// in a first-word fall-through FIFO; redirect flushes the queue and squashes the fetch.
module fetch_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int             CW      = $clog2(DEPTH);
    localparam logic [CW:0]    L_DEPTH = (CW+1)'(DEPTH);
    localparam logic [CW:0]    L_ONE   = (CW+1)'(1);
    localparam logic [CW-1:0]  L_INC   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW:0]   r_count;
    logic [CW-1:0] r_rd_ptr;
    logic [CW-1:0] r_wr_ptr;
    logic [AW-1:0] r_req_pc;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [AW-1:0] r_mem_pc   [DEPTH];

    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_valid;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    // Issue is qualified by rst so request and PC enable stay low while reset is held.
    always_comb begin
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (rst && !bus.redirect && (r_count < L_DEPTH)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    w_state_nxt = bus.imem_ack ? S_IDLE : S_DROP;
                end else if (bus.imem_ack) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (bus.imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.inst_ready && !bus.redirect;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_req_pc <= bus.pc_in;
            end
            if (bus.redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + L_INC;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + L_INC;
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + L_ONE;
                    2'b01:   r_count <= r_count - L_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: queue storage has no reset; the count guards it and outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= bus.imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    assign bus.imem_req   = w_issue;
    assign bus.imem_addr  = bus.pc_in;
    assign bus.pc_enable  = rst && (w_issue || bus.redirect);
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign bus.inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the bench plays PC register and instruction memory and checks
// every cycle against a queue-based model of fetches, redirects and decode pops.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if #(.AW(AW)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: expected queue contents, one outstanding fetch, the PC register and the memory.
    ent_t        q[$];
    bit          outstanding = 1'b0;
    bit          squashed    = 1'b0;
    logic [31:0] req_pc      = '0;
    logic [31:0] pc_model    = '0;
    int          ack_due     = 0;
    int          lat         = 1;
    bit          rand_lat    = 1'b0;
    bit          follow_ack  = 1'b0;
    bit          stray       = 1'b0;
    bit          force_en    = 1'b0;
    logic [31:0] force_data  = '0;
    bit          seen_bad    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check after settling, advance the model.
    task automatic step(input bit rd, input logic [31:0] tgt, input bit rdy);
        bit          ack_now;
        bit          exp_issue;
        bit          ready;
        bit          pop;
        bit          push;
        logic [31:0] data;
        ack_now = 1'b0;
        if (ack_due > 0) begin
            ack_due--;
            ack_now = (ack_due == 0);
        end
        data = $urandom;
        if (ack_now && force_en) begin
            data     = force_data;
            force_en = 1'b0;
        end
        ready          = follow_ack ? ack_now : rdy;
        bus.pc_in      = pc_model;
        bus.redirect   = rd;
        bus.inst_ready = ready;
        bus.imem_ack   = ack_now | stray;
        bus.imem_rdata = data;
        #1;
        exp_issue = !outstanding && !rd && (q.size() < DEPTH);
        check("imem_req", bus.imem_req, exp_issue);
        check("pc_enable", bus.pc_enable, exp_issue | rd);
        check("inst_valid", bus.inst_valid, q.size() != 0);
        if (exp_issue) check("imem_addr", bus.imem_addr, pc_model);
        if (q.size() != 0) begin
            check("inst", bus.inst, q[0].inst);
            check("inst_pc", bus.inst_pc, q[0].pc);
        end
        if (bus.inst_valid && bus.inst == 32'hDEAD_BEEF) seen_bad = 1'b1;

        pop  = (q.size() != 0) && ready && !rd;
        push = outstanding && ack_now && !squashed && !rd;
        if (rd) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{pc: req_pc, inst: data});
        end
        if (outstanding && ack_now) outstanding = 1'b0;
        else if (outstanding && rd) squashed = 1'b1;
        if (exp_issue) begin
            outstanding = 1'b1;
            squashed    = 1'b0;
            req_pc      = pc_model;
            ack_due     = rand_lat ? $urandom_range(1, 4) : lat;
        end
        if (rd) pc_model = tgt;
        else if (exp_issue) pc_model = pc_model + 32'd4;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int guard;
        bus.pc_in      = '0;
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_pc_enable", bus.pc_enable, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        rst = 1'b1;

        // Streaming with one-cycle ack and decode always ready.
        lat = 1;
        repeat (12) step(1'b0, '0, 1'b1);

        // Decode stalled: queue fills, fetching stops, one pop restarts it.
        repeat (14) step(1'b0, '0, 1'b0);
        check("full_stall", q.size(), DEPTH);
        step(1'b0, '0, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0);
        repeat (10) step(1'b0, '0, 1'b1);

        // Redirect while waiting; the late ack carries data that must be dropped.
        lat = 4;
        guard = 0;
        while (!outstanding && guard < 10) begin step(1'b0, '0, 1'b1); guard++; end
        check("wait_issue_a", guard < 10, 1);
        force_en   = 1'b1;
        force_data = 32'hDEAD_BEEF;
        step(1'b1, 32'h100, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);
        check("drop_never_seen", seen_bad, 0);

        // Redirect coinciding with the ack.
        lat = 2;
        guard = 0;
        while (!outstanding && guard < 10) begin step(1'b0, '0, 1'b1); guard++; end
        check("wait_issue_b", guard < 10, 1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);

        // Two entries held while push and pop coincide, wrapping the pointers.
        lat = 1;
        guard = 0;
        while (q.size() < 2 && guard < 20) begin step(1'b0, '0, 1'b0); guard++; end
        check("fill_two", q.size(), 2);
        follow_ack = 1'b1;
        repeat (24) step(1'b0, '0, 1'b0);
        check("hold_two", q.size(), 2);
        follow_ack = 1'b0;

        // Reset while waiting with three entries queued.
        lat = 3;
        guard = 0;
        while (!(q.size() == 3 && outstanding) && guard < 40) begin step(1'b0, '0, 1'b0); guard++; end
        check("fill_three", guard < 40, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_imem_req", bus.imem_req, 0);
        check("mid_rst_pc_enable", bus.pc_enable, 0);
        check("mid_rst_inst_valid", bus.inst_valid, 0);
        check("mid_rst_inst", bus.inst, 0);
        check("mid_rst_inst_pc", bus.inst_pc, 0);
        q.delete();
        outstanding = 1'b0;
        squashed    = 1'b0;
        ack_due     = 0;
        @(negedge clk);
        rst   = 1'b1;
        stray = 1'b1;
        step(1'b0, '0, 1'b1);
        stray = 1'b0;
        repeat (8) step(1'b0, '0, 1'b1);

        // Randomized traffic: latencies, decode stalls and occasional redirects.
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0, 32'($urandom_range(0, 255)) << 2,
                 $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch consumer of the program counter.
- Takes the current PC and advances it via the PC register's enable, one fetch at a time.
- Issues word fetches to instruction memory over a req/ack handshake.
- Queues returned instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready interface.
- Supports redirect (branch/jump): flushes the queue and squashes any in-flight fetch.

Parameters:
DEPTH, 4, instruction queue entries (power of 2, >= 2)
AW, 32, address/PC width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
pc_in  input  AW  current PC from PC register output
pc_enable  output  1  enable to PC register; PC updates at the next edge
redirect  input  1  branch/jump taken this cycle; PC register load is driven externally
imem_req  output  1  fetch request, single-cycle pulse
imem_addr  output  AW  fetch address, valid while imem_req=1
imem_ack  input  1  read data valid; never asserted earlier than 1 cycle after imem_req
imem_rdata  input  32  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  decode accepts head
inst  output  32  head instruction
inst_pc  output  AW  PC of head instruction

Behaviour:
Reset (rst=0, async):
- state=IDLE; FIFO count, read pointer and write pointer = 0; req_pc=0.
- Outputs: imem_req=0, pc_enable=0, inst_valid=0, inst=0, inst_pc=0.

FSM states: IDLE, WAIT, DROP.
- IDLE:
  - issue = !redirect & (count < DEPTH).
  - On issue: imem_req=1, imem_addr=pc_in, req_pc<=pc_in, go WAIT.
  - Otherwise imem_req=0, stay IDLE.
- WAIT:
  - imem_ack & !redirect: push {req_pc, imem_rdata}, go IDLE.
  - redirect (with or without ack): flush; data is not pushed. Go IDLE if ack in the same cycle, else go DROP.
  - Otherwise stay WAIT.
- DROP:
  - imem_ack: discard data, go IDLE.
  - redirect in DROP: flush, stay DROP.

Outputs and handshakes:
- imem_req, imem_addr, pc_enable are combinational from state, count, redirect, pc_in.
- pc_enable = issue | redirect. Redirect needs enable so the PC register can load its target.
- At most one fetch is outstanding. No new request is issued in the cycle an ack arrives, since state is not IDLE then.
- Slot guarantee: at issue count <= DEPTH-1, and no other push can occur before the ack. A push therefore never overflows.

FIFO:
- Registered storage; first-word fall-through.
- inst_valid = (count != 0); inst and inst_pc reflect the head entry.
- Pop on inst_valid & inst_ready.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Pop when empty: ignored. inst and inst_pc are don't-care while inst_valid=0.

Flush (redirect=1):
- count<=0 and pointers<=0 at the edge.
- Any pop or push in that cycle is cancelled.
- inst_valid=0 from the next cycle.

Latency:
- Request in cycle t, ack in cycle t+k (k>=1): entry visible at t+k+1.
- Next request no earlier than t+k+1.
- Peak throughput: 1 instruction per 2 cycles with k=1.

Reset mid-fetch: state returns to IDLE. A later stray imem_ack in IDLE is ignored (no push).

Test Plan:
1. Reset deasserts with pc_in=0x0, ack 1 cycle after each req, inst_ready=1 -> requests at 0x0, 0x4, 0x8 on every other cycle; inst_pc sequence 0x0, 0x4, 0x8 with matching inst; pc_enable pulses only on issue cycles.
2. inst_ready=0, continuous fetching -> exactly 4 pushes, then imem_req stays 0 and pc_enable stays 0 with count=4. One pop -> a new request is issued the cycle after.
3. redirect in WAIT, ack arrives 3 cycles later with 0xDEADBEEF -> FSM passes through DROP; 0xDEADBEEF never appears on inst; inst_valid=0; the next request uses the redirected pc_in (e.g. 0x100).
4. redirect in the same cycle as imem_ack -> data discarded, state IDLE next cycle, FIFO empty, pc_enable=1 during the redirect cycle.
5. FIFO holds 2 entries, push and pop in the same cycle -> count stays 2 and the head advances. Repeat 10 times to exercise pointer wrap; order of inst_pc is preserved.
6. rst asserted while in WAIT with 3 queued entries -> outputs immediately zero, including inst_valid=0. An ack after release is ignored, and fetching restarts from the current pc_in.
